// File: rtl/psum_accumulator_if.sv
// Generic valid/ready stream bundle used for both the psum input and the activation output.
// Ports: valid/data from the producer (master), ready from the consumer (slave).
// Transfer occurs on a rising edge where valid && ready.
interface psum_accumulator_if #(
  parameter int WIDTH = 16
) ();
  logic             valid;
  logic [WIDTH-1:0] data;
  logic             ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/psum_accumulator.sv
// Accumulates num_ch signed psums, adds bias (clamped), ReLU, round-shift, saturate to DATA_WIDTH.
// Latency: last psum accepted at u -> out_valid from u+3; one psum/cycle in ACCUM.
// Backpressure: output held until out.ready; psum_in.ready only in ACCUM; start only in IDLE.
// Ports: clk, rst_n (async active-low); start/num_ch/bias/shift job setup;
//        psum_in (slave stream, PSUM_WIDTH); out (master stream, DATA_WIDTH); busy, done, ovf status.
module psum_accumulator #(
  parameter int DATA_WIDTH = 8,
  parameter int PSUM_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int CH_WIDTH   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [CH_WIDTH-1:0]  num_ch,
  input  logic [ACC_WIDTH-1:0] bias,
  input  logic [4:0]           shift,
  psum_accumulator_if.slave    psum_in,
  psum_accumulator_if.master   out,
  output logic                 busy,
  output logic                 done,
  output logic                 ovf
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACCUM = 3'd1;
  localparam logic [2:0] S_BIAS  = 3'd2;
  localparam logic [2:0] S_QUANT = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;

  localparam logic [ACC_WIDTH-1:0]  ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0]  ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [CH_WIDTH-1:0]   CH_ONE  = {{(CH_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]                  state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic [CH_WIDTH-1:0]         count;
  logic [CH_WIDTH-1:0]         num_ch_q;
  logic [ACC_WIDTH-1:0]        bias_q;
  logic [4:0]                  shift_q;
  logic                        out_vld_q;
  logic [DATA_WIDTH-1:0]       out_dat_q;

  logic                        psum_take;
  logic [ACC_WIDTH-1:0]        psum_ext;
  logic [ACC_WIDTH:0]          bias_sum;
  logic signed [ACC_WIDTH:0]   rnd;
  logic signed [ACC_WIDTH:0]   acc_rnd;
  logic signed [ACC_WIDTH:0]   r;

  assign psum_in.ready = (state == S_ACCUM);
  assign out.valid     = out_vld_q;
  assign out.data      = out_dat_q;
  assign busy          = (state != S_IDLE);

  assign psum_take = psum_in.valid && (state == S_ACCUM);
  assign psum_ext  = {{(ACC_WIDTH-PSUM_WIDTH){psum_in.data[PSUM_WIDTH-1]}}, psum_in.data};

  // Bias add one bit wider so the signed overflow shows up as bit ACC_WIDTH != bit ACC_WIDTH-1.
  assign bias_sum = {acc[ACC_WIDTH-1], acc} + {bias_q[ACC_WIDTH-1], bias_q};

  // Round-half-up: add half an LSB of the shifted result, then arithmetic shift. The extra
  // bit keeps acc + rounding constant from wrapping when acc is near ACC_MAX.
  always_comb begin
    rnd = '0;
    if (shift_q != 5'd0) begin
      rnd = (ACC_WIDTH+1)'(1) << (shift_q - 5'd1);
    end
    acc_rnd = {acc[ACC_WIDTH-1], acc} + rnd;
    r       = acc_rnd >>> shift_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      count     <= '0;
      num_ch_q  <= '0;
      bias_q    <= '0;
      shift_q   <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
      done      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && (num_ch != '0)) begin
            num_ch_q <= num_ch;
            bias_q   <= bias;
            shift_q  <= shift;
            acc      <= '0;
            count    <= '0;
            ovf      <= 1'b0;
            state    <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (psum_take) begin
            acc   <= acc + psum_ext;
            count <= count + CH_ONE;
            if (count == (num_ch_q - CH_ONE)) begin
              state <= S_BIAS;
            end
          end
        end
        S_BIAS: begin
          if (bias_sum[ACC_WIDTH] != bias_sum[ACC_WIDTH-1]) begin
            acc <= bias_sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
          end else begin
            acc <= bias_sum[ACC_WIDTH-1:0];
          end
          state <= S_QUANT;
        end
        S_QUANT: begin
          if (r[ACC_WIDTH]) begin
            out_dat_q <= '0;                       // ReLU, not an overflow
          end else if (r[ACC_WIDTH:DATA_WIDTH-1] != '0) begin
            out_dat_q <= OUT_MAX;
            ovf       <= 1'b1;
          end else begin
            out_dat_q <= r[DATA_WIDTH-1:0];
          end
          out_vld_q <= 1'b1;
          state     <= S_OUT;
        end
        S_OUT: begin
          if (out.ready) begin
            out_vld_q <= 1'b0;
            done      <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
